scct_counter: RTL and testbench

Time base for the SCCT timer. It holds a free-running up-counter behind a programmable prescaler. It drives the shared `counter` / `counter_changed` pair that every scct_channel instance compares against and captures from, and it raises an overflow interrupt. It sits between the register decoder, which drives its `*_i` / `*_wen` strobes, and the bank of channels.

---
 rtl/scct_counter_pkg.sv | 8 +
 rtl/scct_counter_if.sv | 44 ++++
 rtl/scct_prescaler.sv | 31 +++
 rtl/scct_counter.sv | 100 ++++++++++
 tb/tb_scct_counter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/scct_counter_pkg.sv
// Shared constants for the SCCT counter time base.
// The widths must match the scct_channel bank fed by the counter.
package scct_counter_pkg;

  localparam int unsigned SCCT_COUNTER_CTR_WIDTH   = 32'd16;
  localparam int unsigned SCCT_COUNTER_PRESC_WIDTH = 32'd8;

endpackage

// File: rtl/scct_counter_if.sv
// Register-decoder side of the SCCT counter: write strobes in, count and readback out.
interface scct_counter_if
  import scct_counter_pkg::*;
#(
  parameter int unsigned CTR_WIDTH   = SCCT_COUNTER_CTR_WIDTH,
  parameter int unsigned PRESC_WIDTH = SCCT_COUNTER_PRESC_WIDTH
);

  logic                   enable_i;
  logic                   enable_i_wen;
  logic [PRESC_WIDTH-1:0] prescaler_i;
  logic                   prescaler_i_wen;
  logic [CTR_WIDTH-1:0]   counter_i;
  logic                   counter_i_wen;
  logic                   irq_enable_i;
  logic                   irq_enable_i_wen;
  logic                   irq_status_i;
  logic                   irq_status_i_wen;

  logic [CTR_WIDTH-1:0]   counter;
  logic                   counter_changed;
  logic                   ovf_o;
  logic                   enable_o;
  logic [PRESC_WIDTH-1:0] prescaler_o;
  logic                   irq_enable_o;
  logic                   irq_status_o;

  modport master (
    output enable_i, enable_i_wen, prescaler_i, prescaler_i_wen,
           counter_i, counter_i_wen, irq_enable_i, irq_enable_i_wen,
           irq_status_i, irq_status_i_wen,
    input  counter, counter_changed, ovf_o, enable_o, prescaler_o,
           irq_enable_o, irq_status_o
  );

  modport slave (
    input  enable_i, enable_i_wen, prescaler_i, prescaler_i_wen,
           counter_i, counter_i_wen, irq_enable_i, irq_enable_i_wen,
           irq_status_i, irq_status_i_wen,
    output counter, counter_changed, ovf_o, enable_o, prescaler_o,
           irq_enable_o, irq_status_o
  );

endinterface

// File: rtl/scct_prescaler.sv
// Programmable divider: raises tick once every prescaler+1 enabled cycles.
// restart re-phases the divider so the next tick comes a full period later.
module scct_prescaler
  import scct_counter_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = SCCT_COUNTER_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PRESC_WIDTH-1:0] prescaler,
  input  logic                   restart,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] presc_cnt_r;

  assign tick = enable && (presc_cnt_r == prescaler);

  // Phase counter: cleared on restart, when idle, or at the end of each period
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_r <= {PRESC_WIDTH{1'b0}};
    end else if (restart || !enable || tick) begin
      presc_cnt_r <= {PRESC_WIDTH{1'b0}};
    end else begin
      presc_cnt_r <= presc_cnt_r + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/scct_counter.sv
// SCCT time base: prescaled free-running counter shared by the channel bank,
// with overflow pulse, overflow IRQ and register readback.
module scct_counter
  import scct_counter_pkg::*;
#(
  parameter int unsigned CTR_WIDTH   = SCCT_COUNTER_CTR_WIDTH,
  parameter int unsigned PRESC_WIDTH = SCCT_COUNTER_PRESC_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  scct_counter_if.slave  bus
);

  logic                   enable_r;
  logic [PRESC_WIDTH-1:0] prescaler_r;
  logic                   irq_enable_r;
  logic                   irq_status_r;
  logic                   ovf_pend_r;
  logic [CTR_WIDTH-1:0]   counter_r;
  logic                   changed_r;
  logic                   ovf_r;

  logic                   tick_s;
  logic                   restart_s;
  logic                   clear_s;
  logic                   wrap_s;

  assign restart_s = bus.enable_i_wen || bus.prescaler_i_wen || bus.counter_i_wen;
  assign clear_s   = bus.irq_status_i_wen && bus.irq_status_i;
  // A software load suppresses the tick, so it can never flag an overflow
  assign wrap_s    = tick_s && !bus.counter_i_wen && (counter_r == {CTR_WIDTH{1'b1}});

  scct_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable_r),
    .prescaler (prescaler_r),
    .restart   (restart_s),
    .tick      (tick_s)
  );

  // Control registers written by the decoder
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r     <= 1'b0;
      prescaler_r  <= {PRESC_WIDTH{1'b0}};
      irq_enable_r <= 1'b0;
    end else begin
      if (bus.enable_i_wen)     enable_r     <= bus.enable_i;
      if (bus.prescaler_i_wen)  prescaler_r  <= bus.prescaler_i;
      if (bus.irq_enable_i_wen) irq_enable_r <= bus.irq_enable_i;
    end
  end

  // Counter with change and overflow pulses; load beats a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r <= {CTR_WIDTH{1'b0}};
      changed_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (bus.counter_i_wen) begin
      counter_r <= bus.counter_i;
      changed_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (tick_s) begin
      counter_r <= counter_r + {{(CTR_WIDTH-1){1'b0}}, 1'b1};
      changed_r <= 1'b1;
      ovf_r     <= wrap_s;
    end else begin
      changed_r <= 1'b0;
      ovf_r     <= 1'b0;
    end
  end

  // Overflow interrupt: a wrap coincident with a clear keeps the event pending
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend_r   <= 1'b0;
      irq_status_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        ovf_pend_r <= 1'b1;
      end else if (clear_s) begin
        ovf_pend_r <= 1'b0;
      end
      irq_status_r <= clear_s ? 1'b0 : (irq_enable_r && ovf_pend_r);
    end
  end

  assign bus.counter         = counter_r;
  assign bus.counter_changed = changed_r;
  assign bus.ovf_o           = ovf_r;
  assign bus.enable_o        = enable_r;
  assign bus.prescaler_o     = prescaler_r;
  assign bus.irq_enable_o    = irq_enable_r;
  assign bus.irq_status_o    = irq_status_r;

endmodule

// File: tb/tb_scct_counter.sv
// Directed bench for scct_counter: a cycle model built from the tick-period rule
// is compared every cycle, and hand-computed literals pin the model.
module tb_scct_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  scct_counter_if #(.CTR_WIDTH(16), .PRESC_WIDTH(8)) bus ();

  scct_counter #(.CTR_WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model state (values after the most recent edge)
  int m_cnt, m_since, m_p;
  bit m_en, m_chg, m_ovf, m_pend, m_ien, m_stat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the k-th enabled edge after a restart ticks when k is a multiple of P+1
  always @(posedge clk) begin
    bit tick, load, clear, wrap, restart;
    if (rst) begin
      m_cnt = 0; m_since = 0; m_p = 0;
      m_en = 0; m_chg = 0; m_ovf = 0; m_pend = 0; m_ien = 0; m_stat = 0;
    end else begin
      tick    = m_en && (((m_since + 1) % (m_p + 1)) == 0);
      load    = bus.counter_i_wen;
      clear   = bus.irq_status_i_wen && bus.irq_status_i;
      restart = bus.enable_i_wen || bus.prescaler_i_wen || bus.counter_i_wen;
      wrap    = tick && !load && (m_cnt == 65535);
      m_stat  = clear ? 1'b0 : (m_ien && m_pend);
      if (wrap) m_pend = 1'b1;
      else if (clear) m_pend = 1'b0;
      if (load) begin
        m_cnt = int'(bus.counter_i); m_chg = 0; m_ovf = 0;
      end else if (tick) begin
        m_cnt = (m_cnt + 1) % 65536; m_chg = 1; m_ovf = (m_cnt == 0);
      end else begin
        m_chg = 0; m_ovf = 0;
      end
      m_since = (restart || !m_en) ? 0 : m_since + 1;
      if (bus.enable_i_wen) m_en = bus.enable_i;
      if (bus.prescaler_i_wen) m_p = int'(bus.prescaler_i);
      if (bus.irq_enable_i_wen) m_ien = bus.irq_enable_i;
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("counter", 32'(bus.counter), 32'(m_cnt));
      chk("counter_changed", 32'(bus.counter_changed), 32'(m_chg));
      chk("ovf_o", 32'(bus.ovf_o), 32'(m_ovf));
      chk("enable_o", 32'(bus.enable_o), 32'(m_en));
      chk("prescaler_o", 32'(bus.prescaler_o), 32'(m_p));
      chk("irq_enable_o", 32'(bus.irq_enable_o), 32'(m_ien));
      chk("irq_status_o", 32'(bus.irq_status_o), 32'(m_stat));
    end
  end

  // Let one edge sample the strobes set up before the call, then drop them
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.enable_i_wen = 1'b0; bus.prescaler_i_wen = 1'b0; bus.counter_i_wen = 1'b0;
      bus.irq_enable_i_wen = 1'b0; bus.irq_status_i_wen = 1'b0;
    end
  endtask

  task automatic lit(input string name, input logic [15:0] cnt, input logic chg);
    chk({name, "_cnt"}, 32'(bus.counter), 32'(cnt));
    chk({name, "_chg"}, 32'(bus.counter_changed), 32'(chg));
  endtask

  initial begin
    bus.enable_i = 1'b0; bus.prescaler_i = 8'd0; bus.counter_i = 16'd0;
    bus.irq_enable_i = 1'b0; bus.irq_status_i = 1'b0;
    bus.enable_i_wen = 1'b0; bus.prescaler_i_wen = 1'b0; bus.counter_i_wen = 1'b0;
    bus.irq_enable_i_wen = 1'b0; bus.irq_status_i_wen = 1'b0;
    cyc(2);
    check_en = 1'b1;
    lit("reset", 16'h0000, 1'b0);
    chk("reset_enable", 32'(bus.enable_o), 32'd0);
    rst = 1'b0;

    // P=0: counts every cycle with counter_changed held high
    bus.prescaler_i = 8'd0; bus.prescaler_i_wen = 1'b1;
    bus.enable_i = 1'b1; bus.enable_i_wen = 1'b1;
    cyc(1);
    lit("p0_start", 16'h0000, 1'b0);
    cyc(1); lit("p0_1", 16'h0001, 1'b1);
    cyc(1); lit("p0_2", 16'h0002, 1'b1);
    cyc(1); lit("p0_3", 16'h0003, 1'b1);
    chk("p0_ovf", 32'(bus.ovf_o), 32'd0);

    // P=3 written while a P=0 tick is due: that tick still lands, then 4-cycle period
    bus.prescaler_i = 8'd3; bus.prescaler_i_wen = 1'b1;
    cyc(1); lit("p3_w", 16'h0004, 1'b1);
    cyc(3); lit("p3_hold", 16'h0004, 1'b0);
    cyc(1); lit("p3_t1", 16'h0005, 1'b1);
    cyc(1); lit("p3_after", 16'h0005, 1'b0);
    cyc(3); lit("p3_t2", 16'h0006, 1'b1);

    // Wrap with IRQ enabled, then clear
    bus.counter_i = 16'hFFFE; bus.counter_i_wen = 1'b1;
    bus.prescaler_i = 8'd0; bus.prescaler_i_wen = 1'b1;
    bus.irq_enable_i = 1'b1; bus.irq_enable_i_wen = 1'b1;
    cyc(1); lit("ld_fffe", 16'hFFFE, 1'b0);
    cyc(1); lit("ffff", 16'hFFFF, 1'b1);
    cyc(1); lit("wrap", 16'h0000, 1'b1);
    chk("wrap_ovf", 32'(bus.ovf_o), 32'd1);
    chk("wrap_irq_pre", 32'(bus.irq_status_o), 32'd0);
    cyc(1);
    chk("wrap_irq", 32'(bus.irq_status_o), 32'd1);
    chk("wrap_ovf_drop", 32'(bus.ovf_o), 32'd0);
    bus.irq_status_i = 1'b1; bus.irq_status_i_wen = 1'b1;
    cyc(1); chk("irq_clr", 32'(bus.irq_status_o), 32'd0);
    cyc(2); chk("irq_stays_clr", 32'(bus.irq_status_o), 32'd0);

    // Load coincident with a due tick at P=3
    bus.prescaler_i = 8'd3; bus.prescaler_i_wen = 1'b1;
    cyc(4);
    bus.counter_i = 16'h1234; bus.counter_i_wen = 1'b1;
    cyc(1); lit("ld_1234", 16'h1234, 1'b0);
    chk("ld_ovf", 32'(bus.ovf_o), 32'd0);
    cyc(3); lit("ld_hold", 16'h1234, 1'b0);
    cyc(1); lit("ld_next", 16'h1235, 1'b1);

    // Clear coincident with a wrap: the set wins
    bus.counter_i = 16'hFFFF; bus.counter_i_wen = 1'b1;
    bus.prescaler_i = 8'd0; bus.prescaler_i_wen = 1'b1;
    cyc(1);
    bus.irq_status_i = 1'b1; bus.irq_status_i_wen = 1'b1;
    cyc(1); lit("clrwrap", 16'h0000, 1'b1);
    chk("clrwrap_ovf", 32'(bus.ovf_o), 32'd1);
    cyc(1); chk("clrwrap_irq", 32'(bus.irq_status_o), 32'd1);
    cyc(1); chk("clrwrap_irq2", 32'(bus.irq_status_o), 32'd1);

    // Disable mid-period, re-enable: full 4-cycle wait
    bus.counter_i = 16'h0100; bus.counter_i_wen = 1'b1;
    bus.prescaler_i = 8'd3; bus.prescaler_i_wen = 1'b1;
    cyc(3);
    bus.enable_i = 1'b0; bus.enable_i_wen = 1'b1;
    cyc(6); lit("frozen", 16'h0100, 1'b0);
    bus.enable_i = 1'b1; bus.enable_i_wen = 1'b1;
    cyc(4); lit("reen_hold", 16'h0100, 1'b0);
    cyc(1); lit("reen_tick", 16'h0101, 1'b1);

    // Reset mid-count
    bus.counter_i = 16'h0042; bus.counter_i_wen = 1'b1;
    bus.prescaler_i = 8'd5; bus.prescaler_i_wen = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1); lit("rst_mid", 16'h0000, 1'b0);
    chk("rst_enable", 32'(bus.enable_o), 32'd0);
    chk("rst_presc", 32'(bus.prescaler_o), 32'd0);
    chk("rst_irq_en", 32'(bus.irq_enable_o), 32'd0);
    chk("rst_irq_st", 32'(bus.irq_status_o), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
    rst = 1'b0;
    cyc(8); lit("post_rst", 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
